dcr_launch_sequencer: RTL and testbench

DCR_LAUNCH_SEQUENCER -- requirements
Module: dcr_launch_sequencer

---
 rtl/dcr_seq_pkg.sv | 18 +
 rtl/dcr_seq_table.sv | 25 ++
 rtl/dcr_launch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dcr_launch_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcr_seq_pkg.sv
// Shared types for the DCR launch sequencer: FSM state encoding and the table entry layout.
package dcr_seq_pkg;
  localparam int DCR_ADDR_W = 12;
  localparam int DCR_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_BUSY,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DCR_ADDR_W-1:0] addr;
    logic [DCR_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/dcr_seq_table.sv
// DCR entry table: one write port, one combinational read port; contents are not reset.
module dcr_seq_table
  import dcr_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DCR_ADDR_W-1:0] wr_addr,
  input  logic [DCR_DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DCR_ADDR_W-1:0] rd_addr,
  output logic [DCR_DATA_W-1:0] rd_data
);
  entry_t mem [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= '{addr: wr_addr, data: wr_data};
  end

  assign rd_addr = mem[rd_idx].addr;
  assign rd_data = mem[rd_idx].data;
endmodule

// File: rtl/dcr_launch_sequencer.sv
// Replays a programmed list of DCR writes into a core, waits for it to go busy,
// then times the busy period and reports done/err.
module dcr_launch_sequencer
  import dcr_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int WAIT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_wr_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_wr_idx,
  input  logic [11:0]                    cfg_wr_addr,
  input  logic [31:0]                    cfg_wr_data,
  input  logic [$clog2(NUM_ENTRIES):0]   cfg_count,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           busy,
  output logic                           dcr_wr_valid,
  output logic [11:0]                    dcr_wr_addr,
  output logic [31:0]                    dcr_wr_data,
  output logic                           done,
  output logic                           err,
  output logic                           idle,
  output logic [31:0]                    run_cycles
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int CW = IW + 1;
  localparam int WW = $clog2(WAIT_CYCLES + 1);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n, rd_idx;
  logic [CW-1:0]   count, count_n, start_count;
  logic [WW-1:0]   wait_cnt, wait_cnt_n;
  logic            cfg_en, launch, aborting, last_write, wait_expired;
  logic [11:0]     rd_addr, addr_n;
  logic [31:0]     rd_data, data_n, run_n;
  logic            valid_n, err_n, done_n;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign cfg_en       = cfg_wr_valid && (state == IDLE || state == DONE);
  assign start_count  = (cfg_count > CW'(NUM_ENTRIES)) ? CW'(NUM_ENTRIES) : cfg_count;
  assign launch       = (state == IDLE) && start && !abort;
  assign aborting     = (state != IDLE) && abort;
  assign last_write   = ({1'b0, idx} == count - CW'(1));
  assign wait_expired = (wait_cnt == WW'(WAIT_CYCLES - 1));
  // Outputs are registered, so the table is read one entry ahead of what is on the bus.
  assign rd_idx       = (state == WRITE) ? idx + IW'(1) : '0;

  dcr_seq_table #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_table (
    .clk     (clk),
    .wr_en   (cfg_en),
    .wr_idx  (cfg_wr_idx),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_idx  (rd_idx),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (aborting) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      if (launch) state_n = (start_count != '0) ? WRITE : WAIT_BUSY;
        WRITE:     if (last_write) state_n = WAIT_BUSY;
        WAIT_BUSY: if (busy) state_n = RUN;
                   else if (wait_expired) state_n = DONE;
        RUN:       if (!busy) state_n = DONE;
        DONE:      state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  assign done_n = (state_n == DONE);

  always_comb begin
    idx_n      = idx;
    count_n    = count;
    wait_cnt_n = wait_cnt;
    valid_n    = 1'b0;
    addr_n     = dcr_wr_addr;
    data_n     = dcr_wr_data;
    err_n      = err;
    run_n      = run_cycles;
    if (aborting) begin
      err_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            count_n    = start_count;
            idx_n      = '0;
            wait_cnt_n = '0;
            err_n      = 1'b0;
            run_n      = '0;
            if (start_count != '0) begin
              valid_n = 1'b1;
              addr_n  = rd_addr;
              data_n  = rd_data;
            end
          end
        end
        WRITE: begin
          if (!last_write) begin
            idx_n   = idx + IW'(1);
            valid_n = 1'b1;
            addr_n  = rd_addr;
            data_n  = rd_data;
          end else begin
            wait_cnt_n = '0;
          end
        end
        WAIT_BUSY: begin
          if (!busy) begin
            if (wait_expired) err_n = 1'b1;
            else              wait_cnt_n = wait_cnt + WW'(1);
          end
        end
        RUN: begin
          run_n = sat_inc(run_cycles);
          if (!busy) err_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      idle         <= 1'b1;
      run_cycles   <= '0;
    end else begin
      idx          <= idx_n;
      count        <= count_n;
      wait_cnt     <= wait_cnt_n;
      dcr_wr_valid <= valid_n;
      dcr_wr_addr  <= addr_n;
      dcr_wr_data  <= data_n;
      done         <= done_n;
      err          <= err_n;
      idle         <= (state_n == IDLE);
      run_cycles   <= run_n;
    end
  end
endmodule

// File: tb/tb_dcr_launch_sequencer.sv
// Scoreboard bench: stimulus pushes expected DCR writes, done pulses and status probes;
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_dcr_launch_sequencer;
  localparam int NE = 8;
  localparam int WC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_valid = 1'b0;
  logic [2:0]  cfg_wr_idx = '0;
  logic [11:0] cfg_wr_addr = '0;
  logic [31:0] cfg_wr_data = '0;
  logic [3:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy = 1'b0;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic        done;
  logic        err;
  logic        idle;
  logic [31:0] run_cycles;

  dcr_launch_sequencer #(
    .NUM_ENTRIES(NE),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_idx   (cfg_wr_idx),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_count    (cfg_count),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .dcr_wr_valid (dcr_wr_valid),
    .dcr_wr_addr  (dcr_wr_addr),
    .dcr_wr_data  (dcr_wr_data),
    .done         (done),
    .err          (err),
    .idle         (idle),
    .run_cycles   (run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] run;
  } dn_t;
  typedef struct {
    int          cyc;
    logic        valid;
    logic        done;
    logic        err;
    logic        idle;
    logic        bus;
    logic [31:0] run;
  } pr_t;

  wr_t wq[$];
  dn_t dq[$];
  pr_t pq[$];

  logic [11:0] tbl_addr [8] = '{12'h001, 12'h002, 12'h003, 12'h004,
                                12'h005, 12'h006, 12'h007, 12'h008};
  logic [31:0] tbl_data [8] = '{32'hA, 32'hB, 32'hC, 32'hD,
                                32'hE, 32'hF, 32'h10, 32'h11};

  int checks = 0;
  int failures = 0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (dcr_wr_valid) begin
      if (wq.size() == 0) cmp("unexpected_write", 32'(dcr_wr_valid), 32'd0);
      else begin
        wr_t w;
        w = wq.pop_front();
        cmp("wr_cycle", cyc, w.cyc);
        cmp("wr_addr", 32'(dcr_wr_addr), 32'(w.addr));
        cmp("wr_data", dcr_wr_data, w.data);
      end
    end
    if (done) begin
      if (dq.size() == 0) cmp("unexpected_done", 32'(done), 32'd0);
      else begin
        dn_t d;
        d = dq.pop_front();
        cmp("done_cycle", cyc, d.cyc);
        cmp("done_err", 32'(err), 32'(d.err));
        cmp("done_run_cycles", run_cycles, d.run);
      end
    end
    while (pq.size() != 0 && pq[0].cyc <= cyc) begin
      pr_t p;
      p = pq.pop_front();
      if (p.cyc != cyc) cmp("probe_missed", cyc, p.cyc);
      else begin
        cmp("probe_valid", 32'(dcr_wr_valid), 32'(p.valid));
        cmp("probe_done", 32'(done), 32'(p.done));
        cmp("probe_err", 32'(err), 32'(p.err));
        cmp("probe_idle", 32'(idle), 32'(p.idle));
        cmp("probe_run_cycles", run_cycles, p.run);
        if (p.bus) begin
          cmp("probe_addr_zero", 32'(dcr_wr_addr), 32'd0);
          cmp("probe_data_zero", dcr_wr_data, 32'd0);
        end
      end
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      cmp("pending_writes", wq.size(), 32'd0);
      cmp("pending_dones", dq.size(), 32'd0);
      cmp("pending_probes", pq.size(), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic v, input logic dn, input logic e, input logic id,
                       input logic bus, input logic [31:0] r);
    pr_t p;
    p.cyc = cyc; p.valid = v; p.done = dn; p.err = e; p.idle = id; p.bus = bus; p.run = r;
    pq.push_back(p);
  endtask

  task automatic expect_done(input int at, input logic e, input logic [31:0] r);
    dn_t d;
    d.cyc = at; d.err = e; d.run = r;
    dq.push_back(d);
  endtask

  task automatic cfg_write(input logic [2:0] i, input logic [11:0] a, input logic [31:0] d);
    cfg_wr_valid = 1'b1; cfg_wr_idx = i; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  // Start is held for one cycle k; write i is expected on the bus in cycle k+1+i.
  task automatic launch(input logic [3:0] cnt, input int npush, output int k);
    k = cyc;
    start = 1'b1;
    cfg_count = cnt;
    for (int i = 0; i < npush; i++) begin
      wr_t w;
      w.cyc = k + 1 + i; w.addr = tbl_addr[i]; w.data = tbl_data[i];
      wq.push_back(w);
    end
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    tick();
    tick();
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NE; i++) cfg_write(3'(i), tbl_addr[i], tbl_data[i]);

    // Three writes, then a 50-cycle busy period.
    launch(4'd3, 3, k);
    repeat (3) tick();
    probe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    busy = 1'b1;
    repeat (50) tick();
    busy = 1'b0;
    expect_done(k + 55, 1'b0, 32'd50);
    tick();
    tick();
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd50);
    repeat (3) tick();

    // Zero-length list straight to WAIT_BUSY, busy never rises.
    launch(4'd0, 0, k);
    probe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_done(k + 17, 1'b1, 32'd0);
    repeat (17) tick();
    probe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();

    // Abort during the second of four writes.
    launch(4'd4, 2, k);
    probe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    probe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    repeat (20) tick();

    // Start and abort together in IDLE: nothing happens, err holds.
    start = 1'b1; abort = 1'b1; cfg_count = 4'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    probe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    probe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();

    // Oversized count clamps to the table depth; a cfg write mid-run is ignored.
    launch(4'd12, 8, k);
    cfg_write(3'd7, 12'hFFF, 32'hDEAD);
    expect_done(k + 25, 1'b1, 32'd0);
    repeat (25) tick();

    // Reset in RUN, then a normal run using the persisted table.
    launch(4'd1, 1, k);
    tick();
    busy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    tick();
    reset = 1'b0;
    busy = 1'b0;
    tick();
    launch(4'd2, 2, k);
    tick();
    tick();
    busy = 1'b1;
    repeat (5) tick();
    busy = 1'b0;
    expect_done(k + 9, 1'b0, 32'd5);
    repeat (4) tick();
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    tick();

    end_req = 1'b1;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
